aes_ctr_stream_engine: RTL and testbench

Counter-mode AES stream engine that generalises the IV -> AES -> keystream-FIFO -> XOR datapath into a reusable RTL block.
- Accepts IV entropy words and forwards them to an external pipelined AES core that has no output backpressure.
- Buffers the returned W-block keystream and XORs it with a data stream; the same path serves encryption and decryption.
- Adds credit-based issue control so keystream is never dropped, a per-beat bypass mode, and error/status reporting.
- Sits between the ORAM backend data path and the AES core.

---
 rtl/aes_ctr_stream_engine_pkg.sv | 15 +
 rtl/aes_ctr_stream_engine_fifo_linear.sv | 44 ++++
 rtl/aes_ctr_stream_engine.sv | 147 ++++++++++++++
 tb/tb_aes_ctr_stream_engine.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctr_stream_engine_pkg.sv
// Shared defaults and sizing helpers for the AES counter-mode stream engine.
package aes_ctr_stream_engine_pkg;

    localparam int unsigned KS_BLOCKS_DEF    = 4;
    localparam int unsigned AES_WIDTH_DEF    = 128;
    localparam int unsigned IV_WIDTH_DEF     = 64;
    localparam int unsigned KS_DEPTH_DEF     = 16;
    localparam int unsigned CORE_LATENCY_DEF = 12;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/aes_ctr_stream_engine_fifo_linear.sv
// Keystream word buffer: power-of-two ring, occupancy is tracked by the owner.
module aes_ctr_stream_engine_fifo_linear #(
    parameter int unsigned Width = 512,
    parameter int unsigned Depth = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/aes_ctr_stream_engine.sv
// Counter-mode stream engine: credit-gated IV issue to an AES core, keystream
// buffering and a one-register XOR/bypass data path.
module aes_ctr_stream_engine
    import aes_ctr_stream_engine_pkg::*;
#(
    parameter int unsigned W              = KS_BLOCKS_DEF,
    parameter int unsigned AESWidth       = AES_WIDTH_DEF,
    parameter int unsigned IVEntropyWidth = IV_WIDTH_DEF,
    parameter int unsigned KSDepth        = KS_DEPTH_DEF,
    parameter int unsigned CoreLatency    = CORE_LATENCY_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [IVEntropyWidth-1:0]   iv_in_i,
    input  logic                        iv_in_valid_i,
    output logic                        iv_in_ready_o,
    input  logic [W*AESWidth-1:0]       data_in_i,
    input  logic                        data_in_bypass_i,
    input  logic                        data_in_valid_i,
    output logic                        data_in_ready_o,
    output logic [W*AESWidth-1:0]       data_out_o,
    output logic                        data_out_valid_o,
    input  logic                        data_out_ready_i,
    output logic [IVEntropyWidth-1:0]   core_data_in_o,
    output logic                        core_data_in_valid_o,
    input  logic                        core_data_in_ready_i,
    input  logic [W*AESWidth-1:0]       core_data_out_i,
    input  logic                        core_data_out_valid_i,
    output logic [$clog2(KSDepth):0]    in_flight_o,
    output logic [$clog2(KSDepth):0]    ks_count_o,
    output logic                        error_o
);

    localparam int unsigned DataW = W * AESWidth;
    localparam int unsigned CntW  = cnt_width(KSDepth);

    logic [CntW-1:0]  in_flight_q, in_flight_d;
    logic [CntW-1:0]  ks_count_q, ks_count_d;
    logic             error_q, error_d;
    logic             data_out_valid_q, data_out_valid_d;
    logic [DataW-1:0] data_out_q, data_out_d;
    logic [DataW-1:0] ks_head;
    logic [CntW:0]    outstanding_c;
    logic             credit_c, issue_c, ret_ok_c, ret_bad_c, load_c, pop_c;

    // Credit covers both in-flight and buffered words so the core can never overrun the buffer.
    assign outstanding_c        = (CntW+1)'(in_flight_q) + (CntW+1)'(ks_count_q);
    assign credit_c             = outstanding_c < (CntW+1)'(KSDepth);
    assign core_data_in_o       = iv_in_i;
    assign core_data_in_valid_o = iv_in_valid_i & credit_c;
    assign iv_in_ready_o        = core_data_in_ready_i & credit_c;
    assign issue_c              = iv_in_valid_i & iv_in_ready_o;

    assign ret_ok_c  = core_data_out_valid_i & (in_flight_q != '0);
    assign ret_bad_c = core_data_out_valid_i & (in_flight_q == '0);

    assign data_in_ready_o = (~data_out_valid_q | data_out_ready_i)
                           & (data_in_bypass_i | (ks_count_q != '0));
    assign load_c          = data_in_valid_i & data_in_ready_o;
    assign pop_c           = load_c & ~data_in_bypass_i;

    aes_ctr_stream_engine_fifo_linear #(
        .Width (DataW),
        .Depth (KSDepth)
    ) u_ks_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (ret_ok_c),
        .push_data_i (core_data_out_i),
        .pop_i       (pop_c),
        .head_o      (ks_head)
    );

    always_comb begin
        in_flight_d      = in_flight_q;
        ks_count_d       = ks_count_q;
        error_d          = error_q | ret_bad_c;
        data_out_valid_d = data_out_valid_q;
        data_out_d       = data_out_q;

        if (issue_c && !ret_ok_c)      in_flight_d = in_flight_q + CntW'(1);
        else if (!issue_c && ret_ok_c) in_flight_d = in_flight_q - CntW'(1);

        if (ret_ok_c && !pop_c)        ks_count_d = ks_count_q + CntW'(1);
        else if (!ret_ok_c && pop_c)   ks_count_d = ks_count_q - CntW'(1);

        if (load_c) begin
            data_out_d       = data_in_bypass_i ? data_in_i : (data_in_i ^ ks_head);
            data_out_valid_d = 1'b1;
        end else if (data_out_ready_i) begin
            data_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            in_flight_q      <= '0;
            ks_count_q       <= '0;
            error_q          <= 1'b0;
            data_out_valid_q <= 1'b0;
            data_out_q       <= '0;
        end else begin
            in_flight_q      <= in_flight_d;
            ks_count_q       <= ks_count_d;
            error_q          <= error_d;
            data_out_valid_q <= data_out_valid_d;
            data_out_q       <= data_out_d;
        end
    end

    assign in_flight_o      = in_flight_q;
    assign ks_count_o       = ks_count_q;
    assign error_o          = error_q;
    assign data_out_o       = data_out_q;
    assign data_out_valid_o = data_out_valid_q;

`ifndef SYNTHESIS
    // Issue timestamps follow the core's in-order returns to bound its latency.
    localparam int unsigned PtrW = $clog2(KSDepth);

    logic [31:0]     cyc_q;
    logic [31:0]     stamp_q [KSDepth];
    logic [PtrW-1:0] st_wr_q, st_rd_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cyc_q   <= '0;
            st_wr_q <= '0;
            st_rd_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (issue_c) begin
                stamp_q[st_wr_q] <= cyc_q;
                st_wr_q          <= st_wr_q + PtrW'(1);
            end
            if (ret_ok_c) begin
                assert (cyc_q - stamp_q[st_rd_q] <= 32'(CoreLatency))
                    else $error("core returned keystream later than CoreLatency");
                st_rd_q <= st_rd_q + PtrW'(1);
            end
            assert (outstanding_c <= (CntW+1)'(KSDepth))
                else $error("in-flight plus buffered keystream exceeds KSDepth");
        end
    end
`endif

endmodule

// File: tb/tb_aes_ctr_stream_engine.sv
// Scoreboard bench for aes_ctr_stream_engine with a fixed-latency core model.
module tb_aes_ctr_stream_engine;

    localparam int unsigned W   = 4;
    localparam int unsigned AW  = 128;
    localparam int unsigned DW  = W * AW;
    localparam int unsigned IVW = 64;
    localparam int unsigned KSD = 16;
    localparam int unsigned LAT = 12;
    localparam int unsigned CW  = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [IVW-1:0] iv = '0;
    logic           iv_valid = 1'b0;
    logic           iv_ready;
    logic [DW-1:0]  din = '0;
    logic           byp = 1'b0;
    logic           dv = 1'b0;
    logic           d_ready;
    logic [DW-1:0]  dout;
    logic           dov;
    logic           dor = 1'b1;
    logic [IVW-1:0] core_in;
    logic           core_in_valid;
    logic           core_rdy = 1'b1;
    logic [DW-1:0]  core_dat = '0;
    logic           core_vld = 1'b0;
    logic [CW-1:0]  in_flight;
    logic [CW-1:0]  ks_count;
    logic           err;

    aes_ctr_stream_engine #(
        .W(W), .AESWidth(AW), .IVEntropyWidth(IVW), .KSDepth(KSD), .CoreLatency(LAT)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .iv_in_i               (iv),
        .iv_in_valid_i         (iv_valid),
        .iv_in_ready_o         (iv_ready),
        .data_in_i             (din),
        .data_in_bypass_i      (byp),
        .data_in_valid_i       (dv),
        .data_in_ready_o       (d_ready),
        .data_out_o            (dout),
        .data_out_valid_o      (dov),
        .data_out_ready_i      (dor),
        .core_data_in_o        (core_in),
        .core_data_in_valid_o  (core_in_valid),
        .core_data_in_ready_i  (core_rdy),
        .core_data_out_i       (core_dat),
        .core_data_out_valid_i (core_vld),
        .in_flight_o           (in_flight),
        .ks_count_o            (ks_count),
        .error_o               (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Stand-in for the AES core: any fixed, well-mixed function of the IV.
    function automatic logic [DW-1:0] ks_fn(input logic [IVW-1:0] v);
        logic [DW-1:0] r;
        logic [63:0]   x;
        for (int i = 0; i < DW/64; i++) begin
            x = (v ^ 64'(i)) * 64'h9E3779B97F4A7C15;
            x = x ^ (x >> 29);
            r[i*64 +: 64] = x;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_dw();
        logic [DW-1:0] r;
        for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    typedef struct { logic [IVW-1:0] v; int due; } core_t;

    // Reference state: counts, issued IVs, expected outputs and core pipeline.
    int             m_inflight = 0;
    int             m_ks = 0;
    bit             m_err = 1'b0;
    bit             m_dov = 1'b0;
    logic [IVW-1:0] ivq[$];
    logic [DW-1:0]  exp_q[$];
    logic [DW-1:0]  got_q[$];
    core_t          core_q[$];
    bit             iv_acc = 1'b0;
    bit             data_acc = 1'b0;
    bit             inject = 1'b0;
    int             dor_mode = 0;
    bit             core_rand = 1'b0;

    // Reference sampler, just before each rising edge.
    initial begin : sampler
        bit            rdy_iv, rdy_d, iss, ld, credit;
        logic [DW-1:0] e;
        forever begin
            @(negedge clk); #4;
            if (!rst_n) begin
                m_inflight = 0; m_ks = 0; m_err = 0; m_dov = 0;
                ivq.delete(); exp_q.delete(); core_q.delete();
                iv_acc = 0; data_acc = 0;
            end else begin
                credit = (m_inflight + m_ks) < KSD;
                rdy_iv = core_rdy && credit;
                rdy_d  = (!m_dov || dor) && (byp || m_ks != 0);
                check("in_flight",     DW'(in_flight),     DW'(m_inflight));
                check("ks_count",      DW'(ks_count),      DW'(m_ks));
                check("error",         DW'(err),           DW'(m_err));
                check("data_out_valid", DW'(dov),          DW'(m_dov));
                check("iv_in_ready",   DW'(iv_ready),      DW'(rdy_iv));
                check("core_in_valid", DW'(core_in_valid), DW'(iv_valid && credit));
                check("data_in_ready", DW'(d_ready),       DW'(rdy_d));
                iss = iv_valid && rdy_iv;
                ld  = dv && rdy_d;
                if (iss) check("core_data_in", DW'(core_in), DW'(iv));
                if (core_vld) begin
                    if (m_inflight == 0) m_err = 1;
                    else begin m_ks++; m_inflight--; end
                end
                if (iss) begin
                    ivq.push_back(iv);
                    core_q.push_back('{v: iv, due: cyc + 1 + int'(LAT)});
                    m_inflight++;
                end
                if (ld) begin
                    if (byp) e = din;
                    else if (ivq.size() == 0) begin fail_now("keystream_model_empty"); e = din; end
                    else begin e = din ^ ks_fn(ivq.pop_front()); m_ks--; end
                    exp_q.push_back(e);
                    m_dov = 1;
                end else if (dor) begin
                    m_dov = 0;
                end
                iv_acc = iss;
                data_acc = ld;
            end
        end
    end

    // Output monitor: pops the scoreboard on every accepted output beat.
    initial begin : monitor
        bit            stall = 0;
        logic [DW-1:0] stall_data;
        forever begin
            @(negedge clk); #4;
            if (!rst_n) stall = 0;
            else begin
                if (stall) begin
                    check("stall_valid", DW'(dov), DW'(1));
                    check("stall_data", dout, stall_data);
                end
                if (dov && dor) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL data_out: unexpected beat %0h", dout);
                    end else check("data_out", dout, exp_q.pop_front());
                    got_q.push_back(dout);
                    stall = 0;
                end else if (dov) begin
                    stall = 1;
                    stall_data = dout;
                end else stall = 0;
            end
        end
    end

    // Core model: fixed-latency, in-order, no backpressure.
    initial begin : core_model
        forever begin
            @(negedge clk);
            core_vld = 0;
            core_dat = '0;
            if (rst_n) begin
                if (inject) begin
                    core_vld = 1;
                    core_dat = rand_dw();
                end else if (core_q.size() > 0 && core_q[0].due == cyc + 1) begin
                    core_vld = 1;
                    core_dat = ks_fn(core_q[0].v);
                    void'(core_q.pop_front());
                end
            end
        end
    end

    initial begin : ready_drivers
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int k = 0;
        forever begin
            @(negedge clk);
            dor = (dor_mode == 1) ? pat[k % 4] : 1'b1;
            k++;
            core_rdy = core_rand ? ($urandom_range(0, 9) != 0) : 1'b1;
        end
    end

    task automatic send_iv(input logic [IVW-1:0] v, input int gap);
        int n = 0;
        if (gap > 0) begin
            @(negedge clk); iv_valid = 0;
            repeat (gap - 1) @(negedge clk);
        end
        @(negedge clk); iv = v; iv_valid = 1;
        do begin @(posedge clk); n++; end while (!iv_acc && n < 500);
        if (!iv_acc) fail_now("iv_accept");
    endtask

    task automatic send_data(input logic [DW-1:0] d, input bit b, input int gap);
        int n = 0;
        if (gap > 0) begin
            @(negedge clk); dv = 0;
            repeat (gap - 1) @(negedge clk);
        end
        @(negedge clk); din = d; byp = b; dv = 1;
        do begin @(posedge clk); n++; end while (!data_acc && n < 500);
        if (!data_acc) fail_now("data_accept");
    endtask

    task automatic iv_idle();
        @(negedge clk); iv_valid = 0;
    endtask

    task automatic data_idle();
        @(negedge clk); dv = 0; byp = 0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || m_inflight != 0 || dov) && n < 3000) begin
            @(posedge clk); n++;
        end
        if (n >= 3000) fail_now(name);
    endtask

    logic [IVW-1:0] iv_tab [16];
    logic [DW-1:0]  pt_tab [16];
    logic [DW-1:0]  ct_tab [16];

    // Fill to full credit, encrypt 16 words, then decrypt them with the same IVs.
    task automatic roundtrip(input string tag);
        int issued = 0;
        for (int i = 0; i < 16; i++) begin
            iv_tab[i] = {$urandom, $urandom};
            pt_tab[i] = rand_dw();
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            iv = (issued < 16) ? iv_tab[issued] : {$urandom, $urandom};
            iv_valid = 1;
            @(posedge clk);
            if (iv_acc) issued++;
        end
        @(negedge clk); #2;
        check({tag, "_issue_count"}, DW'(issued), DW'(16));
        check({tag, "_iv_ready_full"}, DW'(iv_ready), DW'(0));
        check({tag, "_ks_full"}, DW'(ks_count), DW'(KSD));
        check({tag, "_outstanding"}, DW'(in_flight) + DW'(ks_count), DW'(KSD));
        check({tag, "_no_error"}, DW'(err), DW'(0));
        iv_valid = 0;
        got_q.delete();
        for (int i = 0; i < 16; i++) send_data(pt_tab[i], 1'b0, 0);
        data_idle();
        wait_drain({tag, "_encrypt_drain"});
        check({tag, "_ct_count"}, DW'(got_q.size()), DW'(16));
        for (int i = 0; i < 16; i++) ct_tab[i] = (i < got_q.size()) ? got_q[i] : '0;
        got_q.delete();
        for (int i = 0; i < 16; i++) send_iv(iv_tab[i], 0);
        iv_idle();
        for (int i = 0; i < 16; i++) send_data(ct_tab[i], 1'b0, 0);
        data_idle();
        wait_drain({tag, "_decrypt_drain"});
        check({tag, "_pt_count"}, DW'(got_q.size()), DW'(16));
        for (int i = 0; i < 16; i++)
            check({tag, "_plaintext"}, (i < got_q.size()) ? got_q[i] : '0, pt_tab[i]);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [DW-1:0] a5;
        bit            bp [48];
        int            nks;
        a5 = {64{8'hA5}};

        repeat (3) @(negedge clk);
        check("reset_dov",      DW'(dov),       DW'(0));
        check("reset_dout",     dout,           '0);
        check("reset_err",      DW'(err),       DW'(0));
        check("reset_inflight", DW'(in_flight), DW'(0));
        check("reset_ks",       DW'(ks_count),  DW'(0));
        rst_n = 1;

        roundtrip("first");

        // Bypass with an empty keystream: one-cycle latency, no pop.
        send_data(a5, 1'b1, 0);
        #1;
        check("bypass_valid", DW'(dov), DW'(1));
        check("bypass_data",  dout, a5);
        check("bypass_ks",    DW'(ks_count), DW'(0));
        data_idle();
        wait_drain("bypass_drain");

        // Bypass overtakes a starved keystream.
        send_iv({$urandom, $urandom}, 0);
        iv_idle();
        send_data(rand_dw(), 1'b1, 0);
        #1;
        check("overtake_inflight", DW'(in_flight), DW'(1));
        send_data(rand_dw(), 1'b0, 0);
        data_idle();
        wait_drain("overtake_drain");

        // Random mix under a 1,0,0,1 output stall pattern and random core ready.
        nks = 0;
        for (int i = 0; i < 48; i++) begin
            bp[i] = ($urandom_range(0, 3) == 0);
            if (!bp[i]) nks++;
        end
        dor_mode = 1;
        core_rand = 1;
        fork
            begin
                for (int i = 0; i < nks; i++) send_iv({$urandom, $urandom}, int'($urandom_range(0, 3)));
                iv_idle();
            end
            begin
                for (int i = 0; i < 48; i++) send_data(rand_dw(), bp[i], int'($urandom_range(0, 2)));
                data_idle();
            end
        join
        wait_drain("stress_drain");
        dor_mode = 0;
        core_rand = 0;
        repeat (2) @(negedge clk);

        // Unexpected keystream with nothing in flight.
        @(posedge clk); inject = 1;
        @(posedge clk); inject = 0;
        @(negedge clk);
        check("err_set",      DW'(err),       DW'(1));
        check("err_ks",       DW'(ks_count),  DW'(0));
        check("err_inflight", DW'(in_flight), DW'(0));
        repeat (3) @(negedge clk);
        check("err_sticky",   DW'(err),       DW'(1));
        rst_n = 0;
        @(negedge clk); rst_n = 1;
        check("err_cleared",  DW'(err),       DW'(0));

        // Reset mid-stream with eight IVs in flight.
        begin
            int issued = 0;
            int n = 0;
            while (issued < 8 && n < 200) begin
                @(negedge clk); iv = {$urandom, $urandom}; iv_valid = 1;
                @(posedge clk); n++;
                if (iv_acc) issued++;
            end
            @(negedge clk);
            iv_valid = 0;
            check("mid_inflight", DW'(in_flight), DW'(8));
            rst_n = 0;
            @(negedge clk);
            check("mid_reset_inflight", DW'(in_flight), DW'(0));
            check("mid_reset_ks",       DW'(ks_count),  DW'(0));
            check("mid_reset_dov",      DW'(dov),       DW'(0));
            rst_n = 1;
        end
        repeat (LAT + 4) @(negedge clk);
        roundtrip("after_reset");

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
